simple_cpu_v2: RTL
==================

// Module: simple_cpu_v2
// PURPOSE
//  Parametrised accumulator CPU, successor to the 8-bit single-port core. Adds multi-channel
//  valid/ready I/O with stalls, a carry flag, carry/non-zero branches and a hardware CALL/RET stack.
//  Fetches from an external combinational instruction ROM; one instruction per cycle unless stalled.
// PARAMETERS
//  DATA_WIDTH      8   accumulator, register and I/O word width
//  PC_WIDTH        8   program counter / imem address width
//  ARGUMENT_WIDTH  8   instruction argument field width (>= PC_WIDTH)
//  REGFILE_DEPTH   16  data registers (power of 2); index = arg[$clog2(REGFILE_DEPTH)-1:0]
//  IO_CHANNELS     4   I/O channels (power of 2, >=2); channel = arg[$clog2(IO_CHANNELS)-1:0]
//  STACK_DEPTH     4   return-stack entries
// PORTS
//  clk            in   1                        clock, all state on rising edge
//  rst_n          in   1                        synchronous reset, active low
//  imem_addr      out  PC_WIDTH                 = program_counter
//  imem_data      in   5+ARGUMENT_WIDTH         instruction {opcode[4:0], arg}, same-cycle
//  io_in          in   IO_CHANNELS*DATA_WIDTH   input words, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//  io_in_valid    in   IO_CHANNELS              input word available
//  io_in_ready    out  IO_CHANNELS              comb.: RIO on channel c executing this cycle
//  io_out         out  IO_CHANNELS*DATA_WIDTH   registered output words
//  io_out_valid   out  IO_CHANNELS              output word pending
//  io_out_ready   in   IO_CHANNELS              sink accepts pending word
//  program_counter out PC_WIDTH                 current PC
//  carry          out  1                        carry flag
//  stack_err      out  1                        sticky stack overflow/underflow
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): PC, accumulator, carry, io_out, io_out_valid, stack pointer,
//   stack_err <= 0. Regfile and stack contents not reset. Reset wins over any instruction.
//  Opcodes: 0 NOP,1 LA,2 SA,3 LC,4 RIO,5 WIO,6 ADD,7 SUB,8 NOT,9 OR,10 XOR,11 AND,12 LSH,13 RSH,
//   14 JMP,15 BZ,16 BNZ,17 BC,18 CALL,19 RET,20 HLT (macro), 21-31 NOP.
//  LC: acc <= arg zero-extended/truncated to DATA_WIDTH. Jump targets = arg[PC_WIDTH-1:0].
//  ADD: {carry,acc} <= acc+reg. SUB: {carry,acc} <= acc-reg, carry=1 on borrow. LSH: carry<=acc MSB;
//   RSH: carry<=acc LSB (logical, zero fill). Other ops leave carry unchanged.
//  Branches: BZ if acc==0, BNZ if acc!=0, BC if carry==1; taken -> PC<=target else PC+1. PC wraps.
//  RIO ch: stall (PC, acc hold) while io_in_valid[ch]=0; when 1, acc<=io_in[ch], io_in_ready[ch]=1
//   that cycle only, PC+1. No other ready bit is ever high.
//  WIO ch: if io_out_valid[ch]=1 and io_out_ready[ch]=0 -> stall. Else io_out[ch]<=acc,
//   io_out_valid[ch]<=1, PC+1. Independently, io_out_valid[c] clears when valid&ready and no WIO
//   to c loads it the same cycle (reload wins: stays 1 with new data).
//  CALL: stack not full -> push PC+1, PC<=target. Full -> no push, PC+1, stack_err<=1.
//  RET: stack not empty -> pop, PC<=popped. Empty -> PC+1, stack_err<=1. stack_err sticky to reset.
//  Latency: non-stalled instruction completes in 1 cycle; result visible to next instruction.
// CONFIGURATION
//  SIMPLE_CPU_V2_HALT_EN defined: opcode 20 HLT freezes PC and all state; only reset exits; extra
//   output port 'halted' (1 bit, reset 0, 1 from cycle after HLT). Undefined: opcode 20 is NOP,
//   no 'halted' port.
// TESTING
//  LC 0xF0; SA r1; LC 0x20; ADD r1 -> acc=0x10, carry=1; BC 0x40 -> PC=0x40.
//  LC 0x05; SUB r(=0x06) -> acc=0xFF, carry=1; BNZ taken; LSH -> acc=0xFE, carry=1.
//  RIO ch2 with io_in_valid[2]=0 for 3 cycles then 1 (data 0xA5) -> PC held 3 cycles,
//   io_in_ready=4'b0100 for one cycle, acc=0xA5.
//  WIO ch1 twice with io_out_ready[1]=0 -> 2nd WIO stalls until ready=1; then io_out[1] holds new acc.
//  5 nested CALLs with STACK_DEPTH=4 -> 5th falls through, stack_err=1; 4 RETs unwind correctly;
//   5th RET -> PC+1, stack_err still 1.
//  rst_n low mid-stall on RIO -> next cycle PC=0, acc=0, io_out_valid=0, stack_err=0.

Source files
------------

// File: rtl/simple_cpu_v2.sv
`default_nettype none
// ============================================================================
// Module   : simple_cpu_v2
// Purpose  : Parametrised accumulator CPU with multi-channel valid/ready I/O,
//            carry flag, carry/zero branches and a hardware CALL/RET stack.
//            Fetches from an external combinational instruction ROM and
//            retires one instruction per cycle unless an I/O stall holds it.
// Ports    : clk, rst_n (synchronous, active low)
//            imem_addr / imem_data     instruction fetch (same-cycle data)
//            io_in / io_in_valid / io_in_ready      input channels
//            io_out / io_out_valid / io_out_ready   registered output channels
//            program_counter, carry, stack_err      architectural status
//            halted (only with SIMPLE_CPU_V2_HALT_EN defined)
// Options  : SIMPLE_CPU_V2_HALT_EN - opcode 20 becomes HLT and adds 'halted';
//            undefined, opcode 20 executes as NOP.
// Revision : 1.0 - initial release
// ============================================================================
module simple_cpu_v2 #(
    parameter int DATA_WIDTH     = 8,
    parameter int PC_WIDTH       = 8,
    parameter int ARGUMENT_WIDTH = 8,
    parameter int REGFILE_DEPTH  = 16,
    parameter int IO_CHANNELS    = 4,
    parameter int STACK_DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic [PC_WIDTH-1:0]               imem_addr,
    input  logic [ARGUMENT_WIDTH+4:0]         imem_data,
    input  logic [IO_CHANNELS*DATA_WIDTH-1:0] io_in,
    input  logic [IO_CHANNELS-1:0]            io_in_valid,
    output logic [IO_CHANNELS-1:0]            io_in_ready,
    output logic [IO_CHANNELS*DATA_WIDTH-1:0] io_out,
    output logic [IO_CHANNELS-1:0]            io_out_valid,
    input  logic [IO_CHANNELS-1:0]            io_out_ready,
    output logic [PC_WIDTH-1:0]               program_counter,
    output logic                              carry,
    output logic                              stack_err
`ifdef SIMPLE_CPU_V2_HALT_EN
    ,
    output logic                              halted
`endif
);

    localparam int RF_IDX_W  = $clog2(REGFILE_DEPTH);
    localparam int CH_W      = $clog2(IO_CHANNELS);
    localparam int SP_W      = $clog2(STACK_DEPTH + 1);
    localparam int STK_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] C_SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [4:0] C_OP_LA   = 5'd1;
    localparam logic [4:0] C_OP_SA   = 5'd2;
    localparam logic [4:0] C_OP_LC   = 5'd3;
    localparam logic [4:0] C_OP_RIO  = 5'd4;
    localparam logic [4:0] C_OP_WIO  = 5'd5;
    localparam logic [4:0] C_OP_ADD  = 5'd6;
    localparam logic [4:0] C_OP_SUB  = 5'd7;
    localparam logic [4:0] C_OP_NOT  = 5'd8;
    localparam logic [4:0] C_OP_OR   = 5'd9;
    localparam logic [4:0] C_OP_XOR  = 5'd10;
    localparam logic [4:0] C_OP_AND  = 5'd11;
    localparam logic [4:0] C_OP_LSH  = 5'd12;
    localparam logic [4:0] C_OP_RSH  = 5'd13;
    localparam logic [4:0] C_OP_JMP  = 5'd14;
    localparam logic [4:0] C_OP_BZ   = 5'd15;
    localparam logic [4:0] C_OP_BNZ  = 5'd16;
    localparam logic [4:0] C_OP_BC   = 5'd17;
    localparam logic [4:0] C_OP_CALL = 5'd18;
    localparam logic [4:0] C_OP_RET  = 5'd19;
`ifdef SIMPLE_CPU_V2_HALT_EN
    localparam logic [4:0] C_OP_HLT  = 5'd20;
`endif

    // Architectural state
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  carry_q, carry_d;
    logic [DATA_WIDTH-1:0] io_out_q [IO_CHANNELS];
    logic [DATA_WIDTH-1:0] io_out_d [IO_CHANNELS];
    logic [IO_CHANNELS-1:0] io_out_valid_q, io_out_valid_d;
    logic [SP_W-1:0]       sp_q, sp_d;
    logic                  stack_err_q, stack_err_d;

    // Storage without reset
    logic [DATA_WIDTH-1:0] regfile   [REGFILE_DEPTH];
    logic [PC_WIDTH-1:0]   stack_mem [STACK_DEPTH];

    // Decode
    logic [4:0]                w_opcode;
    logic [ARGUMENT_WIDTH-1:0] w_arg;
    logic [PC_WIDTH-1:0]       w_target;
    logic [RF_IDX_W-1:0]       w_reg_idx;
    logic [CH_W-1:0]           w_ch;
    logic [DATA_WIDTH-1:0]     w_reg_val;
    logic [DATA_WIDTH-1:0]     w_lc_val;
    logic [DATA_WIDTH-1:0]     w_in_words [IO_CHANNELS];
    logic [PC_WIDTH-1:0]       w_pc_inc;
    logic [SP_W-1:0]           w_sp_dec;
    logic                      w_frozen;
    logic                      rf_we;
    logic                      push_we;

    assign w_opcode  = imem_data[ARGUMENT_WIDTH +: 5];
    assign w_arg     = imem_data[ARGUMENT_WIDTH-1:0];
    assign w_target  = w_arg[PC_WIDTH-1:0];
    assign w_reg_idx = w_arg[RF_IDX_W-1:0];
    assign w_ch      = w_arg[CH_W-1:0];
    assign w_reg_val = regfile[w_reg_idx];
    assign w_pc_inc  = pc_q + PC_WIDTH'(1);
    assign w_sp_dec  = sp_q - SP_W'(1);

    generate
        if (ARGUMENT_WIDTH >= DATA_WIDTH) begin : g_lc_trunc
            assign w_lc_val = w_arg[DATA_WIDTH-1:0];
        end else begin : g_lc_ext
            assign w_lc_val = {{(DATA_WIDTH-ARGUMENT_WIDTH){1'b0}}, w_arg};
        end
    endgenerate

    generate
        for (genvar c = 0; c < IO_CHANNELS; c++) begin : g_io_pack
            assign w_in_words[c]                      = io_in[c*DATA_WIDTH +: DATA_WIDTH];
            assign io_out[c*DATA_WIDTH +: DATA_WIDTH] = io_out_q[c];
        end
    endgenerate

`ifdef SIMPLE_CPU_V2_HALT_EN
    logic halted_q, halted_d;
    assign w_frozen = halted_q;
    assign halted   = halted_q;
`else
    assign w_frozen = 1'b0;
`endif

    always_comb begin
        pc_d           = w_pc_inc;
        acc_d          = acc_q;
        carry_d        = carry_q;
        io_out_d       = io_out_q;
        sp_d           = sp_q;
        stack_err_d    = stack_err_q;
        rf_we          = 1'b0;
        push_we        = 1'b0;
        io_in_ready    = '0;
`ifdef SIMPLE_CPU_V2_HALT_EN
        halted_d       = halted_q;
`endif
        // Accepted output words drain regardless of what executes; a WIO to
        // the same channel below re-asserts valid, so reload wins.
        io_out_valid_d = io_out_valid_q & ~io_out_ready;

        case (w_opcode)
            C_OP_LA:  acc_d = w_reg_val;
            C_OP_SA:  rf_we = 1'b1;
            C_OP_LC:  acc_d = w_lc_val;
            C_OP_RIO: begin
                if (io_in_valid[w_ch]) begin
                    acc_d             = w_in_words[w_ch];
                    io_in_ready[w_ch] = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            C_OP_WIO: begin
                if (io_out_valid_q[w_ch] && !io_out_ready[w_ch]) begin
                    pc_d = pc_q;
                end else begin
                    io_out_d[w_ch]       = acc_q;
                    io_out_valid_d[w_ch] = 1'b1;
                end
            end
            C_OP_ADD: {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, w_reg_val};
            // Bit DATA_WIDTH of the extended difference is the borrow.
            C_OP_SUB: {carry_d, acc_d} = {1'b0, acc_q} - {1'b0, w_reg_val};
            C_OP_NOT: acc_d = ~acc_q;
            C_OP_OR:  acc_d = acc_q | w_reg_val;
            C_OP_XOR: acc_d = acc_q ^ w_reg_val;
            C_OP_AND: acc_d = acc_q & w_reg_val;
            C_OP_LSH: begin
                carry_d = acc_q[DATA_WIDTH-1];
                acc_d   = {acc_q[DATA_WIDTH-2:0], 1'b0};
            end
            C_OP_RSH: begin
                carry_d = acc_q[0];
                acc_d   = {1'b0, acc_q[DATA_WIDTH-1:1]};
            end
            C_OP_JMP: pc_d = w_target;
            C_OP_BZ:  if (acc_q == '0) pc_d = w_target;
            C_OP_BNZ: if (acc_q != '0) pc_d = w_target;
            C_OP_BC:  if (carry_q)     pc_d = w_target;
            C_OP_CALL: begin
                if (sp_q != C_SP_FULL) begin
                    push_we = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                    pc_d    = w_target;
                end else begin
                    stack_err_d = 1'b1;
                end
            end
            C_OP_RET: begin
                if (sp_q != '0) begin
                    sp_d = w_sp_dec;
                    pc_d = stack_mem[w_sp_dec[STK_IDX_W-1:0]];
                end else begin
                    stack_err_d = 1'b1;
                end
            end
`ifdef SIMPLE_CPU_V2_HALT_EN
            C_OP_HLT: begin
                pc_d     = pc_q;
                halted_d = 1'b1;
            end
`endif
            default: ;
        endcase

        // Once halted nothing moves until reset.
        if (w_frozen) begin
            pc_d           = pc_q;
            acc_d          = acc_q;
            carry_d        = carry_q;
            io_out_d       = io_out_q;
            io_out_valid_d = io_out_valid_q;
            sp_d           = sp_q;
            stack_err_d    = stack_err_q;
            rf_we          = 1'b0;
            push_we        = 1'b0;
            io_in_ready    = '0;
        end

        // A word offered during reset must not be consumed.
        if (!rst_n) begin
            io_in_ready = '0;
            rf_we       = 1'b0;
            push_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= '0;
            acc_q          <= '0;
            carry_q        <= 1'b0;
            io_out_q       <= '{default: '0};
            io_out_valid_q <= '0;
            sp_q           <= '0;
            stack_err_q    <= 1'b0;
`ifdef SIMPLE_CPU_V2_HALT_EN
            halted_q       <= 1'b0;
`endif
        end else begin
            pc_q           <= pc_d;
            acc_q          <= acc_d;
            carry_q        <= carry_d;
            io_out_q       <= io_out_d;
            io_out_valid_q <= io_out_valid_d;
            sp_q           <= sp_d;
            stack_err_q    <= stack_err_d;
`ifdef SIMPLE_CPU_V2_HALT_EN
            halted_q       <= halted_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) begin
            regfile[w_reg_idx] <= acc_q;
        end
        if (push_we) begin
            stack_mem[sp_q[STK_IDX_W-1:0]] <= w_pc_inc;
        end
    end

    assign imem_addr       = pc_q;
    assign program_counter = pc_q;
    assign carry           = carry_q;
    assign stack_err       = stack_err_q;
    assign io_out_valid    = io_out_valid_q;

endmodule
`default_nettype wire
